b_to_g_counter: RTL and testbench

//  Binary-to-Gray direction of the Gray conversion pair: an up/down counter whose state is

---
 rtl/b_to_g_counter.sv | 85 ++++++++
 tb/tb_b_to_g_counter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/b_to_g_counter.sv
// ---------------------------------------------------------------------------
// b_to_g_counter
//   Up/down counter held in binary and published as registered Gray code.
//   Intended to drive Gray pointers into clock-domain-crossing logic such as
//   async FIFO read/write pointers. A look-ahead Gray value is also provided
//   for full/empty comparison on the local side.
//
// Parameters
//   W          counter/code width in bits (W >= 2)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   en         count enable: advance one step this cycle
//   up         direction: 1 = increment, 0 = decrement
//   load       synchronous load of load_bin (priority over en)
//   load_bin   binary value to load
//   bin        registered binary count
//   gray       registered Gray code of bin
//   gray_next  combinational Gray code of the next en step's value
//   wrap       registered one-cycle pulse: previous step wrapped around
// ---------------------------------------------------------------------------
module b_to_g_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_bin,
  output logic [W-1:0] bin,
  output logic [W-1:0] gray,
  output logic [W-1:0] gray_next,
  output logic         wrap
);

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] gray_q, gray_d;
  logic         wrap_q, wrap_d;
  logic [W-1:0] step_bin;
  logic         at_edge;

  // Value one counting step away in the current direction (modulo 2^W).
  assign step_bin = up ? (bin_q + W'(1)) : (bin_q - W'(1));

  // A counting step from here would cross the range boundary.
  assign at_edge  = up ? (bin_q == {W{1'b1}}) : (bin_q == '0);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      bin_d  = step_bin;
      wrap_d = at_edge;
    end
    // Gray is taken from the next-state binary so bin and gray stay aligned
    // with no extra cycle of latency, while gray itself remains a bare flop.
    gray_d = to_gray(bin_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin       = bin_q;
  assign gray      = gray_q;
  assign wrap      = wrap_q;
  assign gray_next = to_gray(step_bin);

endmodule

// File: tb/tb_b_to_g_counter.sv
module tb_b_to_g_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_bin;
  logic [3:0] bin;
  logic [3:0] gray;
  logic [3:0] gray_next;
  logic       wrap;

  int total;
  int bad;

  logic [3:0] gtab [17];
  logic [3:0] prev_gray;

  b_to_g_counter #(.W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bin (load_bin),
    .bin      (bin),
    .gray     (gray),
    .gray_next(gray_next),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    gtab  = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = 4'h0;

    // Reset asserted between clock edges takes effect immediately.
    #3 rst = 1'b1;
    #1;
    chk("rst_bin",  bin,  4'h0);
    chk("rst_gray", gray, 4'h0);
    chk("rst_wrap", {3'b0, wrap}, 4'h0);
    chk("rst_gnext_up", gray_next, 4'h1);
    up = 1'b0;
    #0.5;
    chk("rst_gnext_dn", gray_next, 4'h8);
    up = 1'b1;
    #3 rst = 1'b0;

    // Full up-count lap from 0 back to 0.
    en = 1'b1; up = 1'b1;
    #1;
    prev_gray = gray;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("up_gnext_%0d", i), gray_next, gtab[i]);
      tick();
      chk($sformatf("up_bin_%0d", i),  bin,  i[3:0]);
      chk($sformatf("up_gray_%0d", i), gray, gtab[i]);
      chk($sformatf("up_wrap_%0d", i), {3'b0, wrap}, (i == 16) ? 4'h1 : 4'h0);
      chk($sformatf("up_onebit_%0d", i), 4'($countones(gray ^ prev_gray)), 4'h1);
      prev_gray = gray;
    end

    // Down count from 0 wraps to F.
    up = 1'b0;
    #1;
    chk("dn_gnext", gray_next, 4'h8);
    tick();
    chk("dn_bin_F",  bin,  4'hF);
    chk("dn_gray_F", gray, 4'h8);
    chk("dn_wrap_F", {3'b0, wrap}, 4'h1);
    tick();
    chk("dn_bin_E",  bin,  4'hE);
    chk("dn_gray_E", gray, 4'h9);
    chk("dn_wrap_E", {3'b0, wrap}, 4'h0);
    tick();
    chk("dn_gray_D", gray, 4'hB);
    tick();
    chk("dn_bin_C",  bin,  4'hC);
    chk("dn_gray_C", gray, 4'hA);

    // Load has priority over en and never pulses wrap.
    load = 1'b1; load_bin = 4'hA; en = 1'b1;
    tick();
    chk("ld_bin",  bin,  4'hA);
    chk("ld_gray", gray, 4'hF);
    chk("ld_wrap", {3'b0, wrap}, 4'h0);
    load = 1'b0; up = 1'b1;
    #1;
    chk("ld_gnext", gray_next, 4'hE);
    tick();
    chk("ld_up_bin",  bin,  4'hB);
    chk("ld_up_gray", gray, 4'hE);

    // Hold with en low.
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold_bin_%0d", i),  bin,  4'hB);
      chk($sformatf("hold_gray_%0d", i), gray, 4'hE);
      chk($sformatf("hold_wrap_%0d", i), {3'b0, wrap}, 4'h0);
    end

    // At F counting up, a concurrent load wins and no wrap is reported.
    load = 1'b1; load_bin = 4'hF; en = 1'b1; up = 1'b1;
    tick();
    chk("pri_bin_F",  bin,  4'hF);
    chk("pri_gray_F", gray, 4'h8);
    load_bin = 4'h3;
    tick();
    chk("pri_bin",  bin,  4'h3);
    chk("pri_gray", gray, 4'h2);
    chk("pri_wrap", {3'b0, wrap}, 4'h0);

    // Reset in the middle of counting abandons the count.
    load_bin = 4'h4;
    tick();
    load = 1'b0;
    tick();
    tick();
    chk("mid_bin_6",  bin,  4'h6);
    chk("mid_gray_6", gray, 4'h5);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_bin",  bin,  4'h0);
    chk("mid_rst_gray", gray, 4'h0);
    chk("mid_rst_wrap", {3'b0, wrap}, 4'h0);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_bin",  bin,  4'h1);
    chk("post_rst_gray", gray, 4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
